// File: rtl/rand_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : rand_fetch
//  Purpose  : Prefetches bytes from a free-running RNG into a small FIFO and
//             serves masked random bytes (CXNN) to the CPU through a
//             request/response handshake.
//  Options  : RAND_DISCARD_EN - when the FIFO is full and no pop occurs, each
//             edge drops the oldest byte and captures a new one.
//  Revision : 1.0 - initial release
// ============================================================================
module rand_fetch #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             rnd_in,
   input  logic                   req,
   input  logic [7:0]             mask,
   input  logic [3:0]             reg_idx,
   output logic                   req_ready,
   output logic                   resp_valid,
   output logic [7:0]             resp_data,
   output logic [3:0]             resp_idx,
   output logic [$clog2(DEPTH):0] fill
);

   localparam int              C_AW   = $clog2(DEPTH);
   localparam logic [C_AW:0]   C_FULL = (C_AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_latch;

   logic [7:0]        r_mem [DEPTH];
   logic [C_AW-1:0]   r_wr_ptr;
   logic [C_AW-1:0]   r_rd_ptr;
   logic [C_AW:0]     r_fill;
   logic [7:0]        r_mask;
   logic [3:0]        r_idx;

   logic              w_full;
   logic              w_pop;
   logic              w_push;
   logic              w_discard;
   logic              w_wr_en;
   logic              w_rd_adv;

   // A pop happens only on the edge leaving RESP; capture continues whenever
   // there is room, so a pop from a non-full FIFO pairs with a push.
   assign w_full  = (r_fill == C_FULL);
   assign w_pop   = (r_state == RESP);
   assign w_push  = !w_full;
`ifdef RAND_DISCARD_EN
   assign w_discard = w_full && !w_pop;
`else
   assign w_discard = 1'b0;
`endif
   assign w_wr_en  = w_push || w_discard;
   assign w_rd_adv = w_pop  || w_discard;

   // Next-state logic; operand latching happens only on acceptance in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      case (r_state)
         IDLE: begin
            if (req) begin
               w_latch     = 1'b1;
               w_state_nxt = (r_fill != '0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (r_fill != '0) w_state_nxt = RESP;
         end
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Latched request operands.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mask <= 8'h00;
         r_idx  <= 4'h0;
      end else if (w_latch) begin
         r_mask <= mask;
         r_idx  <= reg_idx;
      end
   end

   // FIFO pointers and occupancy; a discard moves both pointers, leaving fill.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
      end else begin
         if (w_wr_en)  r_wr_ptr <= r_wr_ptr + C_AW'(1);
         if (w_rd_adv) r_rd_ptr <= r_rd_ptr + C_AW'(1);
         if (w_push && !w_pop)      r_fill <= r_fill + (C_AW+1)'(1);
         else if (w_pop && !w_push) r_fill <= r_fill - (C_AW+1)'(1);
      end
   end

   // FIFO storage; stale contents are unreachable after reset via the pointers.
   always_ff @(posedge clk) begin
      if (!rst && w_wr_en) r_mem[r_wr_ptr] <= rnd_in;
   end

   assign req_ready  = (r_state == IDLE);
   assign resp_valid = (r_state == RESP);
   assign resp_data  = resp_valid ? (r_mem[r_rd_ptr] & r_mask) : 8'h00;
   assign resp_idx   = resp_valid ? r_idx : 4'h0;
   assign fill       = r_fill;

endmodule
`default_nettype wire
